regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between the writeback stage
// (requester 0, fixed priority) and the multi-cycle execution unit
// (requester 1). A bounded-wait counter forces a requester-1 grant after
// MAX_WAIT consecutive lost arbitrations, stalling the pipe for that cycle.
//
// Optional feature macro: REGWB_SCOREBOARD_EN
//   defined   -> busy vector tracks destinations issued to the multi-cycle
//                unit; busy_a/busy_b report pending writes for RA/RB.
//   undefined -> no busy storage; busy_a/busy_b are constant 0.
//
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   wb0_valid/rw/data   requester 0 write request (no back-pressure)
//   wb1_valid/rw/data   requester 1 write request
//   wb1_ready           combinational grant to requester 1
//   stall_pipe          registered, high while the arbiter is in FORCE
//   RegWr/RW/BusW       registered register-file write port
//   issue_valid/rd      multi-cycle op issue (scoreboard set)
//   RA/RB, busy_a/b     scoreboard lookups
//   dbgState            current arbiter state (IDLE=0, WAIT=1, FORCE=2)
//
// Handshake: requester 1 fires when wb1_valid & wb1_ready at posedge; once
// wb1_valid is raised, wb1_valid/wb1_rw/wb1_data stay stable until it fires.
// Requester 0 is never refused except through stall_pipe, which makes the
// upstream stage re-present the same request in the following cycle.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int DATA_W   = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              wb0_valid,
  input  logic [4:0]        wb0_rw,
  input  logic [DATA_W-1:0] wb0_data,
  input  logic              wb1_valid,
  output logic              wb1_ready,
  input  logic [4:0]        wb1_rw,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              stall_pipe,
  output logic              RegWr,
  output logic [4:0]        RW,
  output logic [DATA_W-1:0] BusW,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        RA,
  input  logic [4:0]        RB,
  output logic              busy_a,
  output logic              busy_b,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_LOSS = 4'(MAX_WAIT - 1);
  localparam logic [4:0] XZR       = 5'd31;

  state_t     state, stateNext;
  logic [3:0] waitCnt, waitCntNext;
  logic       fire, loss, win0;

  assign wb1_ready = (state == S_FORCE) | ~wb0_valid;
  assign fire      = wb1_valid & wb1_ready;
  assign loss      = wb1_valid & ~wb1_ready;
  assign win0      = wb0_valid & (state != S_FORCE);
  assign dbgState  = state;

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    // Count consecutive losses only; a fire or a withdrawn request restarts.
    if (loss) waitCntNext = waitCnt + 4'd1;
    else      waitCntNext = 4'd0;
    case (state)
      // IDLE holds waitCnt==0, so with MAX_WAIT==1 the first loss forces.
      S_IDLE, S_WAIT: begin
        if (loss) stateNext = (waitCnt == LAST_LOSS) ? S_FORCE : S_WAIT;
        else      stateNext = S_IDLE;
      end
      S_FORCE: stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      waitCnt    <= 4'd0;
      stall_pipe <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      stall_pipe <= (stateNext == S_FORCE);
    end
  end

  // Write port register. XZR writes are granted but never enabled.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWr <= 1'b0;
      RW    <= XZR;
      BusW  <= '0;
    end else if (win0) begin
      RegWr <= (wb0_rw != XZR);
      RW    <= wb0_rw;
      BusW  <= wb0_data;
    end else if (fire) begin
      RegWr <= (wb1_rw != XZR);
      RW    <= wb1_rw;
      BusW  <= wb1_data;
    end else begin
      RegWr <= 1'b0;
    end
  end

`ifdef REGWB_SCOREBOARD_EN
  // Bit 31 is never set, so lookups of XZR always read 0.
  logic [31:0] busy;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy <= '0;
    end else begin
      if (fire) busy[wb1_rw] <= 1'b0;
      // Issued after the clear so a same-cycle set wins.
      if (issue_valid && issue_rd != XZR) busy[issue_rd] <= 1'b1;
    end
  end

  assign busy_a = busy[RA];
  assign busy_b = busy[RB];
`else
  logic unusedSbInputs;
  assign unusedSbInputs = ^{issue_valid, issue_rd, RA, RB};
  assign busy_a = 1'b0;
  assign busy_b = 1'b0;
`endif

endmodule
